cache_bank_arb: RTL and testbench

Request arbiter and issue sequencer in front of one cache bank. It merges three sources into the bank's single request port: the bus fill-return path and two pipeline requesters (port 0 = load side, port 1 = store side). Issue goes through a one-entry registered stage. The block holds a request while the bank stalls. After a miss it blocks the missing requester until the matching fill has been issued, and it bounds how long fills can starve the pipeline.

---
 rtl/cache_bank_arb.sv | 176 +++++++++++++++++
 tb/tb_cache_bank_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bank_arb.sv
// Arbiter and one-entry issue stage in front of a cache bank: merges bus fills and two
// pipeline ports, holds the issued entry while the bank stalls, and blocks missing ports.
module cache_bank_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill_valid,
  input  logic [14:0]  fill_pAddress,
  input  logic [127:0] fill_data,
  output logic         fill_ready,
  input  logic [1:0]   rq_valid,
  output logic [1:0]   rq_ready,
  input  logic [29:0]  rq_pAddress,
  input  logic [255:0] rq_data,
  input  logic [255:0] rq_mask,
  input  logic [1:0]   rq_w,
  input  logic [13:0]  rq_ptcid,
  output logic         bank_valid,
  output logic [14:0]  bank_pAddress,
  output logic [127:0] bank_data,
  output logic [127:0] bank_mask,
  output logic         bank_r,
  output logic         bank_w,
  output logic         bank_fromBUS,
  output logic [6:0]   bank_ptcid,
  output logic [1:0]   bank_src,
  input  logic         bank_stall,
  input  logic         bank_miss,
  output logic [1:0]   blocked
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 128;
  localparam int unsigned TW = 7;
  localparam int unsigned LW = 11;
  localparam int unsigned CW = 3;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [1:0] SRC_P0   = 2'b00;
  localparam logic [1:0] SRC_P1   = 2'b01;
  localparam logic [1:0] SRC_FILL = 2'b10;

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic          r;
    logic          w;
    logic          from_bus;
    logic [TW-1:0] ptcid;
    logic [1:0]    src;
  } issue_t;

  logic [0:0]    state, state_nxt;
  issue_t        issue_q, issue_d;
  logic [1:0]    blocked_q, blocked_nxt;
  logic [LW-1:0] line_addr [2];
  logic [LW-1:0] line_addr_nxt [2];
  logic          rr, rr_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;

  logic          accept, free;
  logic [1:0]    clr, blk_eff, port_elig;
  logic          gnt_fill, gnt_port, gnt_idx;
  logic [1:0]    gnt_rq;

  // Registered state: issue entry, block flags, round-robin pointer, starvation count
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_EMPTY;
      issue_q    <= '0;
      blocked_q  <= '0;
      line_addr  <= '{default: '0};
      rr         <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      issue_q    <= issue_d;
      blocked_q  <= blocked_nxt;
      line_addr  <= line_addr_nxt;
      rr         <= rr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grant selection and next-state; a fill accepted now can unblock a port for this grant
  always_comb begin
    accept        = (state == S_FULL) && !bank_stall;
    free          = (state == S_EMPTY) || accept;
    state_nxt     = state;
    issue_d       = issue_q;
    blocked_nxt   = blocked_q;
    line_addr_nxt = line_addr;
    rr_nxt        = rr;
    starve_nxt    = starve_cnt;
    gnt_fill      = 1'b0;
    gnt_port      = 1'b0;
    gnt_idx       = 1'b0;
    gnt_rq        = 2'b00;
    clr           = 2'b00;

    for (int i = 0; i < 2; i++) begin
      clr[i] = accept && issue_q.from_bus && (issue_q.addr[AW-1:4] == line_addr[i]);
    end
    blk_eff   = blocked_q & ~clr;
    port_elig = rq_valid & ~blk_eff;

    if (free && !rst) begin
      if ((|port_elig) && ((starve_cnt == STARVE_LIM) || !fill_valid)) begin
        gnt_port = 1'b1;
        gnt_idx  = (&port_elig) ? rr : port_elig[1];
      end else if (fill_valid) begin
        gnt_fill = 1'b1;
      end
    end
    if (gnt_port) gnt_rq[gnt_idx] = 1'b1;

    blocked_nxt = blk_eff;
    if (accept && bank_miss && !issue_q.from_bus) begin
      blocked_nxt[issue_q.src[0]]   = 1'b1;
      line_addr_nxt[issue_q.src[0]] = issue_q.addr[AW-1:4];
    end

    if (gnt_port) begin
      rr_nxt     = ~gnt_idx;
      starve_nxt = '0;
    end else if (gnt_fill && (|port_elig) && (starve_cnt < STARVE_LIM)) begin
      starve_nxt = starve_cnt + CW'(1);
    end

    if (gnt_fill) begin
      issue_d.addr     = fill_pAddress;
      issue_d.data     = fill_data;
      issue_d.mask     = '1;
      issue_d.r        = 1'b0;
      issue_d.w        = 1'b1;
      issue_d.from_bus = 1'b1;
      issue_d.ptcid    = '0;
      issue_d.src      = SRC_FILL;
    end else if (gnt_port) begin
      issue_d.addr     = gnt_idx ? rq_pAddress[2*AW-1:AW] : rq_pAddress[AW-1:0];
      issue_d.data     = gnt_idx ? rq_data[2*DW-1:DW] : rq_data[DW-1:0];
      issue_d.mask     = gnt_idx ? rq_mask[2*DW-1:DW] : rq_mask[DW-1:0];
      issue_d.r        = ~rq_w[gnt_idx];
      issue_d.w        = rq_w[gnt_idx];
      issue_d.from_bus = 1'b0;
      issue_d.ptcid    = gnt_idx ? rq_ptcid[2*TW-1:TW] : rq_ptcid[TW-1:0];
      issue_d.src      = gnt_idx ? SRC_P1 : SRC_P0;
    end

    if (gnt_fill || gnt_port) begin
      state_nxt = S_FULL;
    end else if (accept) begin
      state_nxt = S_EMPTY;
    end
  end

  assign fill_ready    = gnt_fill;
  assign rq_ready      = gnt_rq;
  assign bank_valid    = (state == S_FULL);
  assign bank_pAddress = issue_q.addr;
  assign bank_data     = issue_q.data;
  assign bank_mask     = issue_q.mask;
  assign bank_r        = issue_q.r;
  assign bank_w        = issue_q.w;
  assign bank_fromBUS  = issue_q.from_bus;
  assign bank_ptcid    = issue_q.ptcid;
  assign bank_src      = issue_q.src;
  assign blocked       = blocked_q;

endmodule

// File: tb/tb_cache_bank_arb.sv
// Directed bench for cache_bank_arb: issue latency, round robin, starvation limit,
// stall hold, miss blocking and mid-run reset.
module tb_cache_bank_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic         fill_valid;
  logic [14:0]  fill_pAddress;
  logic [127:0] fill_data;
  logic         fill_ready;
  logic [1:0]   rq_valid;
  logic [1:0]   rq_ready;
  logic [29:0]  rq_pAddress;
  logic [255:0] rq_data;
  logic [255:0] rq_mask;
  logic [1:0]   rq_w;
  logic [13:0]  rq_ptcid;
  logic         bank_valid;
  logic [14:0]  bank_pAddress;
  logic [127:0] bank_data;
  logic [127:0] bank_mask;
  logic         bank_r;
  logic         bank_w;
  logic         bank_fromBUS;
  logic [6:0]   bank_ptcid;
  logic [1:0]   bank_src;
  logic         bank_stall;
  logic         bank_miss;
  logic [1:0]   blocked;

  int n_cmp = 0;
  int n_err = 0;

  cache_bank_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .fill_valid(fill_valid), .fill_pAddress(fill_pAddress), .fill_data(fill_data),
    .fill_ready(fill_ready),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_pAddress(rq_pAddress),
    .rq_data(rq_data), .rq_mask(rq_mask), .rq_w(rq_w), .rq_ptcid(rq_ptcid),
    .bank_valid(bank_valid), .bank_pAddress(bank_pAddress), .bank_data(bank_data),
    .bank_mask(bank_mask), .bank_r(bank_r), .bank_w(bank_w),
    .bank_fromBUS(bank_fromBUS), .bank_ptcid(bank_ptcid), .bank_src(bank_src),
    .bank_stall(bank_stall), .bank_miss(bank_miss), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    fill_valid    = 1'b0;
    fill_pAddress = '0;
    fill_data     = '0;
    rq_valid      = 2'b00;
    rq_pAddress   = '0;
    rq_data       = '0;
    rq_mask       = '0;
    rq_w          = 2'b00;
    rq_ptcid      = '0;
    bank_stall    = 1'b0;
    bank_miss     = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    rq_valid = 2'b11;
    fill_valid = 1'b1;
    #1;
    n_cmp++; if (rq_ready !== 2'b00) begin n_err++; $display("FAIL reset_rq_ready got %b want 00", rq_ready); end
    n_cmp++; if (fill_ready !== 1'b0) begin n_err++; $display("FAIL reset_fill_ready got %b want 0", fill_ready); end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++; if (bank_valid !== 1'b0) begin n_err++; $display("FAIL reset_bank_valid got %b want 0", bank_valid); end
    n_cmp++; if (blocked !== 2'b00) begin n_err++; $display("FAIL reset_blocked got %b want 00", blocked); end
    n_cmp++; if (bank_pAddress !== 15'h0 || bank_src !== 2'b00 || bank_mask !== '0)
      begin n_err++; $display("FAIL reset_fields got addr %h src %b want 0", bank_pAddress, bank_src); end
  endtask

  task automatic test_single_read;
    do_reset();
    rq_valid = 2'b01;
    rq_pAddress[14:0] = 15'h0123;
    rq_data[127:0] = 128'hDEAD_BEEF;
    rq_ptcid[6:0] = 7'h15;
    #1;
    n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", rq_ready); end
    tick();
    rq_valid = 2'b00;
    #1;
    n_cmp++; if (bank_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bank_valid); end
    n_cmp++; if (bank_pAddress !== 15'h0123) begin n_err++; $display("FAIL single_addr got %h want 0123", bank_pAddress); end
    n_cmp++; if (bank_r !== 1'b1 || bank_w !== 1'b0) begin n_err++; $display("FAIL single_rw got r%b w%b want r1 w0", bank_r, bank_w); end
    n_cmp++; if (bank_src !== 2'b00) begin n_err++; $display("FAIL single_src got %b want 00", bank_src); end
    n_cmp++; if (bank_ptcid !== 7'h15 || bank_fromBUS !== 1'b0) begin n_err++; $display("FAIL single_tag got %h/%b want 15/0", bank_ptcid, bank_fromBUS); end
    tick();
    n_cmp++; if (bank_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", bank_valid); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_rdy;
    logic [1:0] prev_src;
    do_reset();
    rq_pAddress = {15'h0222, 15'h0111};
    rq_w = 2'b10;
    for (int k = 0; k < 4; k++) begin
      rq_valid = 2'b11;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_cmp++; if (rq_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant%0d got %b want %b", k, rq_ready, exp_rdy); end
      if (k > 0) begin
        n_cmp++; if (bank_src !== prev_src) begin n_err++; $display("FAIL rr_src%0d got %b want %b", k, bank_src, prev_src); end
      end
      prev_src = (k % 2 == 0) ? 2'b00 : 2'b01;
      tick();
    end
    rq_valid = 2'b00;
    #1;
    n_cmp++; if (bank_src !== 2'b01 || bank_w !== 1'b1 || bank_pAddress !== 15'h0222)
      begin n_err++; $display("FAIL rr_last got src %b w %b addr %h want 01 1 0222", bank_src, bank_w, bank_pAddress); end
    tick();
  endtask

  task automatic test_starve;
    logic       exp_fill;
    logic [1:0] exp_rdy;
    logic [1:0] prev_src;
    do_reset();
    fill_valid = 1'b1;
    fill_pAddress = 15'h7FF0;
    fill_data = 128'h1234;
    rq_valid = 2'b10;
    rq_pAddress[29:15] = 15'h0333;
    for (int k = 0; k < 6; k++) begin
      exp_fill = (k != 4);
      exp_rdy = (k == 4) ? 2'b10 : 2'b00;
      #1;
      n_cmp++; if (fill_ready !== exp_fill || rq_ready !== exp_rdy)
        begin n_err++; $display("FAIL starve_grant%0d got fill %b rq %b want %b %b", k, fill_ready, rq_ready, exp_fill, exp_rdy); end
      if (k > 0) begin
        n_cmp++; if (bank_src !== prev_src) begin n_err++; $display("FAIL starve_src%0d got %b want %b", k, bank_src, prev_src); end
      end
      if (k == 1) begin
        n_cmp++; if (bank_fromBUS !== 1'b1 || bank_mask !== {128{1'b1}} || bank_r !== 1'b0 || bank_w !== 1'b1 || bank_ptcid !== 7'h0)
          begin n_err++; $display("FAIL fill_fields got bus %b r %b w %b tag %h", bank_fromBUS, bank_r, bank_w, bank_ptcid); end
      end
      prev_src = (k == 4) ? 2'b01 : 2'b10;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall;
    do_reset();
    rq_valid = 2'b01;
    rq_pAddress = {15'h0555, 15'h0111};
    #1;
    n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL stall_first got %b want 01", rq_ready); end
    tick();
    rq_valid = 2'b11;
    rq_pAddress = {15'h0555, 15'h0444};
    bank_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (rq_ready !== 2'b00 || fill_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d got %b/%b want 00/0", k, rq_ready, fill_ready); end
      n_cmp++; if (bank_valid !== 1'b1 || bank_pAddress !== 15'h0111 || bank_src !== 2'b00)
        begin n_err++; $display("FAIL stall_hold%0d got v%b addr %h src %b want 1 0111 00", k, bank_valid, bank_pAddress, bank_src); end
      tick();
    end
    bank_stall = 1'b0;
    #1;
    n_cmp++; if (rq_ready !== 2'b10) begin n_err++; $display("FAIL stall_release got %b want 10", rq_ready); end
    tick();
    rq_valid = 2'b00;
    #1;
    n_cmp++; if (bank_valid !== 1'b1 || bank_pAddress !== 15'h0555 || bank_src !== 2'b01)
      begin n_err++; $display("FAIL stall_next got v%b addr %h src %b want 1 0555 01", bank_valid, bank_pAddress, bank_src); end
    tick();
  endtask

  task automatic test_miss_block;
    do_reset();
    rq_valid = 2'b01;
    rq_pAddress = {15'h0200, 15'h0450};
    #1;
    n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL miss_first got %b want 01", rq_ready); end
    tick();
    rq_valid = 2'b10;
    bank_miss = 1'b1;
    #1;
    n_cmp++; if (rq_ready !== 2'b10) begin n_err++; $display("FAIL miss_p1a got %b want 10", rq_ready); end
    tick();
    bank_miss = 1'b0;
    rq_valid = 2'b11;
    #1;
    n_cmp++; if (blocked !== 2'b01) begin n_err++; $display("FAIL miss_blocked got %b want 01", blocked); end
    n_cmp++; if (rq_ready !== 2'b10) begin n_err++; $display("FAIL miss_p0_ignored got %b want 10", rq_ready); end
    tick();
    rq_valid = 2'b01;
    fill_valid = 1'b1;
    fill_pAddress = 15'h045C;
    #1;
    n_cmp++; if (fill_ready !== 1'b1 || rq_ready !== 2'b00) begin n_err++; $display("FAIL miss_fill got fill %b rq %b want 1 00", fill_ready, rq_ready); end
    tick();
    fill_valid = 1'b0;
    #1;
    n_cmp++; if (bank_fromBUS !== 1'b1 || bank_pAddress !== 15'h045C) begin n_err++; $display("FAIL miss_fill_issue got bus %b addr %h want 1 045c", bank_fromBUS, bank_pAddress); end
    n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL miss_unblock_grant got %b want 01", rq_ready); end
    tick();
    rq_valid = 2'b00;
    #1;
    n_cmp++; if (blocked !== 2'b00) begin n_err++; $display("FAIL miss_cleared got %b want 00", blocked); end
    n_cmp++; if (bank_src !== 2'b00 || bank_pAddress !== 15'h0450) begin n_err++; $display("FAIL miss_reissue got src %b addr %h want 00 0450", bank_src, bank_pAddress); end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    rq_valid = 2'b01;
    rq_pAddress = {15'h0300, 15'h0100};
    tick();
    rq_valid = 2'b10;
    bank_miss = 1'b1;
    tick();
    rq_valid = 2'b00;
    fill_valid = 1'b1;
    fill_pAddress = 15'h7000;
    tick();
    bank_miss = 1'b0;
    fill_valid = 1'b0;
    bank_stall = 1'b1;
    #1;
    n_cmp++; if (blocked !== 2'b11 || bank_valid !== 1'b1) begin n_err++; $display("FAIL mid_setup got blocked %b valid %b want 11 1", blocked, bank_valid); end
    rst = 1'b1;
    rq_valid = 2'b11;
    #1;
    n_cmp++; if (rq_ready !== 2'b00) begin n_err++; $display("FAIL mid_rst_ready got %b want 00", rq_ready); end
    tick();
    rst = 1'b0;
    bank_stall = 1'b0;
    #1;
    n_cmp++; if (bank_valid !== 1'b0 || blocked !== 2'b00) begin n_err++; $display("FAIL mid_cleared got valid %b blocked %b want 0 00", bank_valid, blocked); end
    n_cmp++; if (rq_ready !== 2'b01) begin n_err++; $display("FAIL mid_first got %b want 01", rq_ready); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_starve();
    test_stall();
    test_miss_block();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
